// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forward encodings, pipeline slot record and Tnew helper for hazard_scoreboard
package hazard_pkg;
    localparam int REG_AW = 5;
    localparam int TNEW_W = 2;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_E  = 2'b11;
    typedef struct packed {
        logic [REG_AW-1:0] a3;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              regWrite;
        logic [TNEW_W-1:0] tnew;
        logic              md_start;
    } slot_t;
    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction
endpackage

// File: rtl/md_busy_ctr.sv
// md_busy_ctr: mult/div busy timer, loaded on issue and counted down to zero
module md_busy_ctr #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] lat,
    output logic          busy
);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= lat;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall/forward control from a private E/M/W metadata pipeline plus mult/div busy interlock
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int AW      = REG_AW,
    parameter int TW      = TNEW_W,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] D_rs,
    input  logic [AW-1:0] D_rt,
    input  logic          D_rs_use,
    input  logic          D_rt_use,
    input  logic [TW-1:0] D_rs_tuse,
    input  logic [TW-1:0] D_rt_tuse,
    input  logic [AW-1:0] D_A3,
    input  logic          D_regWrite,
    input  logic [TW-1:0] D_tnew,
    input  logic          D_md_start,
    input  logic          D_md_div,
    input  logic          D_md_use,
    output logic          stall,
    output logic          md_busy,
    output logic [1:0]    RD1_sel,
    output logic [1:0]    RD2_sel,
    output logic [1:0]    E_rs_sel,
    output logic [1:0]    E_rt_sel,
    output logic          M_rt_sel
);
    slot_t e_q, m_q, w_q, d_slot, m_next, w_next;
    logic  rs_stall, rt_stall;
    logic  unused_slot;

    function automatic logic fwd_ok(input slot_t s, input logic [AW-1:0] r);
        return s.regWrite && s.a3 != '0 && s.a3 == r && s.tnew == '0;
    endfunction

    function automatic logic not_ready(input slot_t s, input logic [AW-1:0] r, input logic [TW-1:0] tuse);
        return s.regWrite && s.a3 != '0 && s.a3 == r && tuse < s.tnew;
    endfunction

    always_comb begin
        d_slot = '{a3: D_A3, rs: D_rs, rt: D_rt, regWrite: D_regWrite, tnew: D_tnew, md_start: D_md_start};
        m_next = e_q;
        m_next.tnew = sat_dec(e_q.tnew);
        w_next = m_q;
        w_next.tnew = '0;
        rs_stall = D_rs_use && (not_ready(e_q, D_rs, D_rs_tuse) || not_ready(m_q, D_rs, D_rs_tuse));
        rt_stall = D_rt_use && (not_ready(e_q, D_rt, D_rt_tuse) || not_ready(m_q, D_rt, D_rt_tuse));
        stall = rs_stall || rt_stall || (D_md_use && md_busy);
        RD1_sel = fwd_ok(e_q, D_rs) ? FWD_E : fwd_ok(m_q, D_rs) ? FWD_M : fwd_ok(w_q, D_rs) ? FWD_W : FWD_RF;
        RD2_sel = fwd_ok(e_q, D_rt) ? FWD_E : fwd_ok(m_q, D_rt) ? FWD_M : fwd_ok(w_q, D_rt) ? FWD_W : FWD_RF;
        E_rs_sel = fwd_ok(m_q, e_q.rs) ? FWD_M : fwd_ok(w_q, e_q.rs) ? FWD_W : FWD_RF;
        E_rt_sel = fwd_ok(m_q, e_q.rt) ? FWD_M : fwd_ok(w_q, e_q.rt) ? FWD_W : FWD_RF;
        M_rt_sel = fwd_ok(w_q, m_q.rt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= stall ? '0 : d_slot;
            m_q <= m_next;
            w_q <= w_next;
        end
    end

    md_busy_ctr #(.CW(CW)) u_md_busy_ctr (
        .clk   (clk),
        .reset (reset),
        .load  (D_md_start && !stall),
        .lat   (D_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT)),
        .busy  (md_busy)
    );

    assign unused_slot = ^{e_q, m_q, w_q};
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed MIPS hazard sequences with a queued expectation scoreboard
module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, D_A3;
    logic       D_rs_use, D_rt_use, D_regWrite, D_md_start, D_md_div, D_md_use;
    logic [1:0] D_rs_tuse, D_rt_tuse, D_tnew;
    logic       stall, md_busy, M_rt_sel;
    logic [1:0] RD1_sel, RD2_sel, E_rs_sel, E_rt_sel;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        string       tag;
        logic [10:0] v;
    } exp_t;
    exp_t sb[$];

    hazard_scoreboard dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_rs_use(D_rs_use), .D_rt_use(D_rt_use),
        .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse), .D_A3(D_A3),
        .D_regWrite(D_regWrite), .D_tnew(D_tnew), .D_md_start(D_md_start),
        .D_md_div(D_md_div), .D_md_use(D_md_use),
        .stall(stall), .md_busy(md_busy), .RD1_sel(RD1_sel), .RD2_sel(RD2_sel),
        .E_rs_sel(E_rs_sel), .E_rt_sel(E_rt_sel), .M_rt_sel(M_rt_sel)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] ev(input logic s, input logic b, input logic [1:0] r1, input logic [1:0] r2,
                                       input logic [1:0] er, input logic [1:0] et, input logic mr);
        return {s, b, r1, r2, er, et, mr};
    endfunction

    task automatic drive(input logic [4:0] rs, input logic rsu, input logic [1:0] rstu,
                         input logic [4:0] rt, input logic rtu, input logic [1:0] rttu,
                         input logic [4:0] a3, input logic rw, input logic [1:0] tn,
                         input logic ms, input logic mdv, input logic mu);
        D_rs = rs; D_rs_use = rsu; D_rs_tuse = rstu;
        D_rt = rt; D_rt_use = rtu; D_rt_tuse = rttu;
        D_A3 = a3; D_regWrite = rw; D_tnew = tn;
        D_md_start = ms; D_md_div = mdv; D_md_use = mu;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step(input string tag, input logic [10:0] e);
        exp_t x;
        sb.push_back('{tag, e});
        @(negedge clk);
        if (sb.size() != 0) begin
            x = sb.pop_front();
            checks++;
            assert ({stall, md_busy, RD1_sel, RD2_sel, E_rs_sel, E_rt_sel, M_rt_sel} === x.v)
            else begin
                errors++;
                $error("FAIL %s: observed %b expected %b", x.tag,
                       {stall, md_busy, RD1_sel, RD2_sel, E_rs_sel, E_rt_sel, M_rt_sel}, x.v);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        nop();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step("reset_state", ev(0, 0, 0, 0, 0, 0, 0));
        // lw $1 then add $2,$1,$1: one bubble, then W->E forward
        drive(5, 1, 1, 0, 0, 0, 1, 1, 2, 0, 0, 0);
        step("lw_issue", ev(0, 0, 0, 0, 0, 0, 0));
        drive(1, 1, 1, 1, 1, 1, 2, 1, 1, 0, 0, 0);
        step("loaduse_stall", ev(1, 0, 0, 0, 0, 0, 0));
        step("loaduse_release", ev(0, 0, 0, 0, 0, 0, 0));
        nop();
        step("add_in_E_fwd_W", ev(0, 0, 0, 0, 2'b01, 2'b01, 0));
        step("quiet_after_add", ev(0, 0, 0, 0, 0, 0, 0));
        // jal then jr $31
        drive(0, 0, 0, 0, 0, 0, 31, 1, 0, 0, 0, 0);
        step("jal_issue", ev(0, 0, 0, 0, 0, 0, 0));
        drive(31, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("jr_fwd_E", ev(0, 0, 2'b11, 0, 0, 0, 0));
        nop();
        step("jr_in_E_fwd_M", ev(0, 0, 0, 0, 2'b10, 0, 0));
        step("drain1", ev(0, 0, 0, 0, 0, 0, 0));
        // ori $3 ; ori $3 ; beq $3,$0
        drive(0, 1, 1, 0, 0, 0, 3, 1, 1, 0, 0, 0);
        step("ori1", ev(0, 0, 0, 0, 0, 0, 0));
        step("ori2", ev(0, 0, 0, 0, 0, 0, 0));
        drive(3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("beq_stall_E_not_ready", ev(1, 0, 2'b10, 0, 0, 0, 0));
        step("beq_newest_M", ev(0, 0, 2'b10, 0, 0, 0, 0));
        nop();
        step("beq_in_E_fwd_W", ev(0, 0, 0, 0, 2'b01, 0, 0));
        step("drain2", ev(0, 0, 0, 0, 0, 0, 0));
        // div then mflo: 10 stall cycles
        drive(4, 1, 1, 5, 1, 1, 0, 0, 0, 1, 1, 1);
        step("div_issue", ev(0, 0, 0, 0, 0, 0, 0));
        drive(0, 0, 0, 0, 0, 0, 8, 1, 1, 0, 0, 1);
        for (int i = 0; i < 10; i++) step($sformatf("mflo_wait%0d", i), ev(1, 1, 0, 0, 0, 0, 0));
        step("mflo_advance", ev(0, 0, 0, 0, 0, 0, 0));
        nop();
        step("after_mflo", ev(0, 0, 0, 0, 0, 0, 0));
        // mult then mfhi: 5 stall cycles
        drive(6, 1, 1, 7, 1, 1, 0, 0, 0, 1, 0, 1);
        step("mult_issue", ev(0, 0, 0, 0, 0, 0, 0));
        drive(0, 0, 0, 0, 0, 0, 10, 1, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step($sformatf("mfhi_wait%0d", i), ev(1, 1, 0, 0, 0, 0, 0));
        step("mfhi_advance", ev(0, 0, 0, 0, 0, 0, 0));
        nop();
        step("after_mfhi", ev(0, 0, 0, 0, 0, 0, 0));
        // reset while div timer at 7, with a competing md_start and writer in D
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        step("div2_issue", ev(0, 0, 0, 0, 0, 0, 0));
        nop();
        for (int i = 0; i < 3; i++) step($sformatf("busy_no_user%0d", i), ev(0, 1, 0, 0, 0, 0, 0));
        drive(0, 0, 0, 0, 0, 0, 9, 1, 1, 1, 1, 0);
        reset = 1'b1;
        step("pre_reset_busy", ev(0, 1, 0, 0, 0, 0, 0));
        reset = 1'b0;
        drive(9, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        step("post_reset_clear", ev(0, 0, 0, 0, 0, 0, 0));
        nop();
        step("post_reset_E", ev(0, 0, 0, 0, 0, 0, 0));
        // writers to $0 never forward or stall
        drive(0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step("zero_w1", ev(0, 0, 0, 0, 0, 0, 0));
        step("zero_w2", ev(0, 0, 0, 0, 0, 0, 0));
        step("zero_w3", ev(0, 0, 0, 0, 0, 0, 0));
        drive(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("zero_reader", ev(0, 0, 0, 0, 0, 0, 0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the five-stage MIPS pipeline: stall and forwarding control plus a busy timer for a multi-cycle mult/div unit. Unlike the purely combinational predecessor, it keeps its own pipelined copy of hazard metadata (destination, write-enable, Tnew, source registers) for E/M/W. It decrements Tnew per stage, inserts bubbles on stall, and blocks HI/LO users while mult/div is busy. It sits beside the datapath and is driven only by decode-stage information.

## Interface
- AW, 5: register-address width.
- TW, 2: Tuse/Tnew width.
- MUL_LAT, 5: mult busy cycles.
- DIV_LAT, 10: div busy cycles.
- CW, 4: busy-counter width; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- D_rs, D_rt  in  AW  source registers of the D instruction.
- D_rs_use, D_rt_use  in  1  source actually read.
- D_rs_tuse, D_rt_tuse  in  TW  cycles until the source is consumed.
- D_A3  in  AW  destination.
- D_regWrite  in  1  D instruction writes the GPR file.
- D_tnew  in  TW  Tnew the instruction will have in E.
- D_md_start  in  1  mult/multu/div/divu.
- D_md_div  in  1  with D_md_start: selects DIV_LAT.
- D_md_use  in  1  uses HI/LO (mfhi/mflo/mthi/mtlo and md starts).
- stall  out  1  freeze PC and F/D; bubble into E.
- md_busy  out  1  busy counter nonzero.
- RD1_sel, RD2_sel  out  2  D-stage rs/rt forward select.
- E_rs_sel, E_rt_sel  out  2  E-stage rs/rt forward select.
- M_rt_sel  out  1  M-stage store-data forward; 1 = W.

## Operation
- Forward encoding: 00 = register/pipeline value; 01 = from W; 10 = from M; 11 = from E (D consumers only).
- A stage is a valid forward source when regWrite=1, A3≠0, A3 = consumer register, and stage Tnew = 0. W Tnew is always 0.
- When several stages match, the newest wins (E > M > W).
- rs stall: D_rs_use, D_rs≠0, and one of:
  - E-slot match with D_rs_tune < E_tnew;
  - M-slot match with D_rs_tuse < M_tnew.
- rt stall: same rule using rt.
- md stall: D_md_use && md_busy.
- stall = rs stall | rt stall | md stall.
- Slot update on every clk:
  - E ← D fields, or a bubble (regWrite=0, md_start=0) if stall.
  - M ← E, with tnew = sat_dec(E_tnew).
  - W ← M, with tnew forced to 0.
- Bubbles never match.
- Tnew arithmetic is unsigned and saturates at 0. No wrap.
- Busy counter:
  - On the edge where a D_md_start instruction advances (not stalled), load MUL_LAT or DIV_LAT.
  - Otherwise decrement if nonzero.
  - md_busy = (cnt≠0).
- No flush input: delay-slot semantics, slots never killed.

## Timing
- Reset: all slots are bubbles, cnt = 0. Outputs then read stall=0, md_busy=0, all selects 0.
- Reset beats every simultaneous event, including a mid-operation md timer.
- stall and all selects are combinational from D inputs and slot registers. Latency is 0 cycles.
- Metadata reaches E 1 cycle after D, M after 2, W after 3.
- md_busy is high for exactly LAT consecutive cycles, starting the cycle the md instruction occupies E.
- A second md_start in D while busy stalls until the cycle after cnt reaches 0.
- A load-use pair (lw then add using the load result) gives one stall cycle. The add then sees RD sel 10 from M in D, or 01 from W in E, as appropriate.

## Structure
- Package hazard_pkg holds:
  - FWD_RF/FWD_W/FWD_M/FWD_E localparams;
  - the slot struct {a3, rs, rt, regWrite, tnew, md_start};
  - the sat_dec function.
- Sub-module md_busy_ctr (clk, reset, load, lat, busy) holds the counter.
- The slot pipeline and compare logic live in the top module.

## Test plan
- Reset mid-div (cnt=7) → next cycle cnt=0, md_busy=0, all slots bubbles, stall=0.
- lw $1 (D_tnew=2) then add $2,$1,$1 (tuse=1) → stall for 1 cycle. Next cycle E_rs_sel=E_rt_sel=10? No: the add reaches E with lw in W, so E_rs_sel=E_rt_sel=01.
- jal (A3=31, tnew=0) followed by jr $31 (tuse=0) → no stall, RD1_sel=11.
- ori $3 then ori $3 then beq $3,$0 → RD1_sel=11 is not taken. E has Tnew 1, so stall 1 cycle, then RD1_sel=10 (newest instance).
- div (DIV_LAT=10) then mflo → stall high 10 cycles, mflo advances on the 11th.
- mult (MUL_LAT=5) then mfhi → stall 5 cycles.
- Writes to $0 from E/M/W with D_rs=0 → stall=0, all selects 00.
